checksum_generation: RTL and testbench

//  Checksum generator for the fault-tolerant 32x32 matrix-multiply accelerator (ABFT).

---
 rtl/checksum_generation.sv | 202 ++++++++++++++++++++
 tb/tb_checksum_generation.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/checksum_generation.sv
// Checksum generator for the ABFT 32x32 matrix-multiply accelerator.
// The A path collects rows of matrix A into mem_ac, builds a column-checksum
// row in mem_ac[N], and delivers one element (column mux_sel) per fetch.
// The B path latches each row of matrix B, appends its row sum, and streams
// (N+1)-word rows while fetch_B is held high.
//
// Handshakes:
//   fetch_A is a level request sampled for a rising edge. Each accepted rise
//   yields exactly one fetch_A_ready pulse, three clocks after the edge that
//   samples the rise, with dataAc_out valid in the same cycle.
//   fetch_B is a level request. While it is high, each row is taken from
//   data_in and dataBr_out_ready pulses for one cycle with dataBr_out valid.
//   The source advances data_in after that pulse. fetch_B low aborts and
//   rewinds the B row counter.
//
// FSM state is visible on the internal signals a_state and b_state.
module checksum_generation #(
  parameter int W = 32,
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*W-1:0]       data_in,
  input  logic [4:0]           mux_sel,
  input  logic [1:0]           detect_correct,
  input  logic                 generate_enable,
  input  logic                 fetch_A,
  input  logic                 fetch_B,
  output logic [W-1:0]         dataAc_out,
  output logic [(N+1)*W-1:0]   dataBr_out,
  output logic                 dataBr_out_ready,
  output logic                 fetch_A_ready,
  output logic                 fetch_B_ready,
  output logic [2:0]           full
);

  // Row counters must reach N+1 (one past the checksum row).
  localparam int RW = $clog2(N + 2);
  localparam int IW = $clog2(N);
  localparam logic [RW-1:0] ROWS      = RW'(N);
  localparam logic [RW-1:0] ROWS_EXT  = RW'(N + 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(N - 1);

  typedef enum logic [1:0] {A_IDLE, A_WAIT, A_CAP, A_OUT} a_state_t;
  typedef enum logic [1:0] {B_IDLE, B_CAP, B_OUT} b_state_t;

  a_state_t a_state;
  b_state_t b_state;

  // mem_ac[0..N-1] hold A rows; mem_ac[N] is the running column checksum.
  logic [W-1:0]       mem_ac [0:N][0:N-1];
  // Each B row is stored with its row sum in the top word.
  logic [(N+1)*W-1:0] mem_br [0:N-1];

  logic [RW-1:0] row_a;
  logic [RW-1:0] row_b;
  logic          fetch_a_q;
  logic [1:0]    dc_q;

  logic [RW-1:0] pass_len;
  logic [RW-1:0] pass_last;
  logic [2:0]    mode_bit;
  logic          mode_change;
  logic          a_start;
  logic [W-1:0]  row_sum;
  logic [IW-1:0] row_b_idx;

  assign row_b_idx = row_b[IW-1:0];

  // Pass length, pass-done flag bit and fetch acceptance for the current mode.
  always_comb begin
    pass_len  = ROWS;
    mode_bit  = 3'b000;
    case (detect_correct)
      2'd1: begin
        pass_len = ROWS_EXT;
        mode_bit = 3'b001;
      end
      2'd2: mode_bit = 3'b010;
      2'd3: mode_bit = 3'b100;
      default: mode_bit = 3'b000;
    endcase
    pass_last   = pass_len - RW'(1);
    mode_change = (detect_correct != dc_q);
    a_start     = generate_enable && (detect_correct != 2'd0) &&
                  fetch_A && !fetch_a_q && (row_a < pass_len) && !mode_change;
  end

  // Row sum of the incoming B row, wrapping mod 2^W.
  always_comb begin
    row_sum = '0;
    for (int j = 0; j < N; j++) begin
      row_sum = row_sum + data_in[W*j +: W];
    end
  end

  // A path: edge-detected fetch, capture into mem_ac, deliver one column element.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_state       <= A_IDLE;
      row_a         <= '0;
      fetch_a_q     <= 1'b0;
      dc_q          <= 2'd0;
      dataAc_out    <= '0;
      fetch_A_ready <= 1'b0;
      full          <= 3'b000;
      for (int i = 0; i <= N; i++) begin
        for (int j = 0; j < N; j++) begin
          mem_ac[i][j] <= '0;
        end
      end
    end else begin
      fetch_a_q     <= fetch_A;
      dc_q          <= detect_correct;
      fetch_A_ready <= 1'b0;
      if (mode_change) begin
        // A new mode starts a fresh pass; any in-flight fetch is dropped.
        row_a   <= '0;
        full    <= 3'b000;
        a_state <= A_IDLE;
      end else if (!generate_enable) begin
        a_state <= A_IDLE;
      end else begin
        case (a_state)
          A_IDLE: begin
            if (a_start) a_state <= A_WAIT;
          end
          A_WAIT: begin
            // Source presents the row on data_in during this cycle.
            a_state <= A_CAP;
          end
          A_CAP: begin
            // The extra fetch of a detect pass carries no data.
            if (row_a < ROWS) begin
              for (int j = 0; j < N; j++) begin
                mem_ac[row_a][j] <= data_in[W*j +: W];
                mem_ac[N][j]     <= ((row_a == '0) ? '0 : mem_ac[N][j]) +
                                    data_in[W*j +: W];
              end
            end
            a_state <= A_OUT;
          end
          A_OUT: begin
            dataAc_out    <= mem_ac[row_a][mux_sel];
            fetch_A_ready <= 1'b1;
            row_a         <= row_a + RW'(1);
            if (row_a == pass_last) full <= mode_bit;
            a_state       <= A_IDLE;
          end
          default: a_state <= A_IDLE;
        endcase
      end
    end
  end

  // B path: stream rows while fetch_B is high, appending the row sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_state          <= B_IDLE;
      row_b            <= '0;
      dataBr_out       <= '0;
      dataBr_out_ready <= 1'b0;
      fetch_B_ready    <= 1'b0;
      for (int i = 0; i < N; i++) begin
        mem_br[i] <= '0;
      end
    end else begin
      dataBr_out_ready <= 1'b0;
      if (!fetch_B) begin
        // Dropping the request rewinds the stream.
        row_b         <= '0;
        fetch_B_ready <= 1'b0;
        b_state       <= B_IDLE;
      end else if (!generate_enable) begin
        b_state <= B_IDLE;
      end else begin
        case (b_state)
          B_IDLE: begin
            if (row_b < ROWS) b_state <= B_CAP;
          end
          B_CAP: begin
            mem_br[row_b_idx] <= {row_sum, data_in};
            b_state           <= B_OUT;
          end
          B_OUT: begin
            dataBr_out       <= mem_br[row_b_idx];
            dataBr_out_ready <= 1'b1;
            row_b            <= row_b + RW'(1);
            if (row_b == LAST_ROW) begin
              fetch_B_ready <= 1'b1;
              b_state       <= B_IDLE;
            end else begin
              b_state <= B_CAP;
            end
          end
          default: b_state <= B_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_checksum_generation.sv
// Directed bench for checksum_generation: B streaming, the three A passes,
// B abort/restart, reset during capture and generate_enable gating.
module tb_checksum_generation;

  localparam int W = 32;
  localparam int N = 32;

  logic                 clk;
  logic                 rst;
  logic [N*W-1:0]       data_in;
  logic [4:0]           mux_sel;
  logic [1:0]           detect_correct;
  logic                 generate_enable;
  logic                 fetch_A;
  logic                 fetch_B;
  logic [W-1:0]         dataAc_out;
  logic [(N+1)*W-1:0]   dataBr_out;
  logic                 dataBr_out_ready;
  logic                 fetch_A_ready;
  logic                 fetch_B_ready;
  logic [2:0]           full;

  int n_pass  = 0;
  int n_total = 0;

  checksum_generation #(.W(W), .N(N)) dut (
    .clk              (clk),
    .rst              (rst),
    .data_in          (data_in),
    .mux_sel          (mux_sel),
    .detect_correct   (detect_correct),
    .generate_enable  (generate_enable),
    .fetch_A          (fetch_A),
    .fetch_B          (fetch_B),
    .dataAc_out       (dataAc_out),
    .dataBr_out       (dataBr_out),
    .dataBr_out_ready (dataBr_out_ready),
    .fetch_A_ready    (fetch_A_ready),
    .fetch_B_ready    (fetch_B_ready),
    .full             (full)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------

  // One fetch_A pulse; reports whether a ready pulse came, its latency in
  // clocks after the sampling edge, and dataAc_out at that pulse.
  task automatic fetch_a(output bit got, output int lat, output logic [W-1:0] val);
    got = 1'b0;
    lat = 0;
    val = '0;
    @(negedge clk);
    fetch_A = 1'b1;
    @(negedge clk);
    fetch_A = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (!got && fetch_A_ready) begin
        got = 1'b1;
        lat = i;
        val = dataAc_out;
      end
    end
  endtask

  // Bounded wait for a dataBr_out_ready pulse, sampled on negedges.
  task automatic wait_b(output bit got);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = dataBr_out_ready;
    end
  endtask

  function automatic logic [N*W-1:0] all_words(input logic [W-1:0] v);
    logic [N*W-1:0] r;
    for (int j = 0; j < N; j++) r[W*j +: W] = v;
    return r;
  endfunction

  // ---------------- tests ----------------

  task automatic test_reset;
    n_total++;
    if (dataAc_out !== '0 || dataBr_out !== '0 || dataBr_out_ready !== 1'b0 ||
        fetch_A_ready !== 1'b0 || fetch_B_ready !== 1'b0 || full !== 3'b000) begin
      $display("FAIL reset_outputs: Ac=%h Br_rdy=%b A_rdy=%b B_rdy=%b full=%b, required all 0",
               dataAc_out, dataBr_out_ready, fetch_A_ready, fetch_B_ready, full);
    end else n_pass++;
  endtask

  // Row k carries 2 in word k only; expected row sum is 2.
  task automatic test_b_stream;
    bit got;
    logic [(N+1)*W-1:0] exp;
    @(negedge clk);
    data_in = '0;
    data_in[0 +: W] = 32'd2;
    fetch_B = 1'b1;
    for (int k = 0; k < N; k++) begin
      wait_b(got);
      exp = '0;
      exp[W*k +: W] = 32'd2;
      exp[W*N +: W] = 32'd2;
      n_total++;
      if (!got || dataBr_out !== exp) begin
        $display("FAIL b_row%0d: got_ready=%b word%0d=%h sum=%h, required word%0d=2 sum=2",
                 k, got, k, dataBr_out[W*k +: W], dataBr_out[W*N +: W], k);
      end else n_pass++;
      if (k == N - 2) begin
        n_total++;
        if (fetch_B_ready !== 1'b0) $display("FAIL b_ready_early: fetch_B_ready=%b, required 0", fetch_B_ready);
        else n_pass++;
      end
      data_in = '0;
      if (k + 1 < N) data_in[W*(k+1) +: W] = 32'd2;
    end
    n_total++;
    if (fetch_B_ready !== 1'b1) $display("FAIL b_ready_done: fetch_B_ready=%b, required 1", fetch_B_ready);
    else n_pass++;
    wait_b(got);
    n_total++;
    if (got || fetch_B_ready !== 1'b1) begin
      $display("FAIL b_hold: extra_pulse=%b fetch_B_ready=%b, required 0/1", got, fetch_B_ready);
    end else n_pass++;
    fetch_B = 1'b0;
    @(negedge clk);
    n_total++;
    if (fetch_B_ready !== 1'b0) $display("FAIL b_ready_drop: fetch_B_ready=%b, required 0", fetch_B_ready);
    else n_pass++;
  endtask

  // One full A pass of `count` fetches with all-ones data; the fetch after
  // the 32 data rows (detect mode) returns the column checksum 32.
  task automatic run_a_pass(input logic [1:0] mode, input int count,
                            input logic [W-1:0] word, input logic [2:0] exp_full);
    bit got;
    int lat;
    logic [W-1:0] val;
    logic [W-1:0] exp;
    detect_correct = mode;
    data_in = all_words(word);
    repeat (2) @(negedge clk);
    n_total++;
    if (full !== 3'b000) $display("FAIL full_clear_m%0d: full=%b, required 000", mode, full);
    else n_pass++;
    for (int f = 0; f < count; f++) begin
      fetch_a(got, lat, val);
      exp = (f == N) ? word * N : word;
      n_total++;
      if (!got || lat != 3 || val !== exp) begin
        $display("FAIL a_m%0d_fetch%0d: ready=%b latency=%0d value=%0d, required ready=1 latency=3 value=%0d",
                 mode, f, got, lat, val, exp);
      end else n_pass++;
      if (f == count - 2) begin
        n_total++;
        if (full !== 3'b000) $display("FAIL full_early_m%0d: full=%b, required 000", mode, full);
        else n_pass++;
      end
    end
    n_total++;
    if (full !== exp_full) $display("FAIL full_m%0d: full=%b, required %b", mode, full, exp_full);
    else n_pass++;
  endtask

  task automatic test_mode1;
    mux_sel = 5'd20;
    generate_enable = 1'b1;
    run_a_pass(2'd1, N + 1, 32'd1, 3'b001);
  endtask

  task automatic test_mode2;
    run_a_pass(2'd2, N, 32'd1, 3'b010);
  endtask

  task automatic test_mode3;
    bit got;
    int lat;
    logic [W-1:0] val;
    run_a_pass(2'd3, N, 32'd1, 3'b100);
    fetch_a(got, lat, val);
    n_total++;
    if (got) $display("FAIL a_after_pass_end: fetch_A_ready=1, required none");
    else n_pass++;
  endtask

  // Row k is all k; expected sum 32*k. Abort after 5 rows and restart.
  task automatic test_b_abort;
    bit got;
    logic [(N+1)*W-1:0] exp;
    @(negedge clk);
    data_in = all_words(32'd0);
    fetch_B = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_b(got);
      n_total++;
      if (!got || dataBr_out[W*N +: W] !== 32'(N * k)) begin
        $display("FAIL abort_pre_row%0d: ready=%b sum=%0d, required %0d", k, got, dataBr_out[W*N +: W], N * k);
      end else n_pass++;
      data_in = all_words(32'(k + 1));
    end
    fetch_B = 1'b0;
    data_in = all_words(32'd0);
    @(negedge clk);
    n_total++;
    if (fetch_B_ready !== 1'b0) $display("FAIL abort_ready: fetch_B_ready=%b, required 0", fetch_B_ready);
    else n_pass++;
    fetch_B = 1'b1;
    for (int k = 0; k < N; k++) begin
      wait_b(got);
      exp = {32'(N * k), all_words(32'(k))};
      n_total++;
      if (!got || dataBr_out !== exp) begin
        $display("FAIL restart_row%0d: ready=%b word0=%0d sum=%0d, required %0d/%0d",
                 k, got, dataBr_out[0 +: W], dataBr_out[W*N +: W], k, N * k);
      end else n_pass++;
      if (k == N - 2) begin
        n_total++;
        if (fetch_B_ready !== 1'b0) $display("FAIL restart_ready_early: fetch_B_ready=%b, required 0", fetch_B_ready);
        else n_pass++;
      end
      data_in = all_words(32'(k + 1));
    end
    n_total++;
    if (fetch_B_ready !== 1'b1) $display("FAIL restart_ready_done: fetch_B_ready=%b, required 1", fetch_B_ready);
    else n_pass++;
    n_total++;
    if (dataAc_out !== 32'd1 || full !== 3'b100) begin
      $display("FAIL b_disturbs_a: dataAc_out=%0d full=%b, required 1/100", dataAc_out, full);
    end else n_pass++;
    fetch_B = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_cap;
    bit got;
    int lat;
    logic [W-1:0] val;
    detect_correct = 2'd1;
    data_in = all_words(32'd7);
    repeat (2) @(negedge clk);
    fetch_A = 1'b1;
    @(negedge clk);
    fetch_A = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (dataAc_out !== '0 || dataBr_out !== '0 || full !== 3'b000 ||
        fetch_A_ready !== 1'b0 || fetch_B_ready !== 1'b0 || dataBr_out_ready !== 1'b0) begin
      $display("FAIL async_reset: dataAc_out=%0d Br_sum=%0d full=%b, required all 0",
               dataAc_out, dataBr_out[W*N +: W], full);
    end else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    // Fresh detect pass from row 0: 32 sevens then checksum 224.
    run_a_pass(2'd1, N + 1, 32'd7, 3'b001);
    // Gating: with generate_enable low nothing is served.
    generate_enable = 1'b0;
    detect_correct = 2'd2;
    repeat (2) @(negedge clk);
    fetch_a(got, lat, val);
    n_total++;
    if (got) $display("FAIL gate_a: fetch_A_ready seen, required none");
    else n_pass++;
    fetch_B = 1'b1;
    wait_b(got);
    n_total++;
    if (got) $display("FAIL gate_b: dataBr_out_ready seen, required none");
    else n_pass++;
    fetch_B = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    data_in = '0;
    mux_sel = '0;
    detect_correct = 2'd0;
    generate_enable = 1'b1;
    fetch_A = 1'b0;
    fetch_B = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_reset;
    test_b_stream;
    test_mode1;
    test_mode2;
    test_mode3;
    test_b_abort;
    test_reset_mid_cap;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
